// File: rtl/s2p_rx_pkg.sv
// Shared ADC/serial-link parameters and the receiver FSM state encoding.
// Both the row serializers and their s2p_rx counterparts use these values.
package s2p_rx_pkg;

    localparam int BITS_ADC   = 12;
    localparam int WORD_W     = BITS_ADC + 1;
    localparam int BIT_CYCLES = 12;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT    = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

endpackage

// File: rtl/s2p_rx_if.sv
// Serial input and FIFO read-side bundle of one row receiver.
// The master drives the serial stream and pops words; the receiver is the slave.
interface s2p_rx_if #(
    parameter int WIDTH = s2p_rx_pkg::WORD_W
) ();

    logic             s_data;
    logic             data_valid;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;

    modport master (
        output s_data, data_valid, rd_en,
        input  rd_data, empty, full
    );

    modport slave (
        input  s_data, data_valid, rd_en,
        output rd_data, empty, full
    );

endinterface

// File: rtl/s2p_rx_fifo.sv
// First-word-fall-through synchronous FIFO: rd_data always shows the head entry.
// A pop on a full FIFO frees the slot that a simultaneous push then uses.
module sync_fifo_fwft #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/s2p_rx.sv
// Per-row serial-to-parallel receiver: mid-bit samples a framed MSB-first stream,
// buffers complete words in a FWFT FIFO and reports framing errors and overflow.
module s2p_rx #(
    parameter int BITS_ADC   = s2p_rx_pkg::BITS_ADC,
    parameter int BIT_CYCLES = s2p_rx_pkg::BIT_CYCLES,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_50M,
    input  logic             rst,
    s2p_rx_if.slave          bus,
    input  logic             clr_err,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] word_cnt
);

    import s2p_rx_pkg::*;

    localparam int DATA_W = BITS_ADC + 1;
    localparam int PH_W   = $clog2(BIT_CYCLES);
    localparam int BI_W   = $clog2(DATA_W);

    state_t            state;
    logic              dv_q;
    logic [PH_W-1:0]   phase;
    logic [BI_W-1:0]   bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              push_q;
    logic              sample;
    logic              last_sample;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;

    assign sample      = (phase == PH_W'(BIT_CYCLES / 2));
    assign last_sample = sample && (bit_idx == BI_W'(DATA_W - 1));
    assign push_ok     = push_q && (!fifo_full || (bus.rd_en && !fifo_empty));
    assign bus.full    = fifo_full;
    assign bus.empty   = fifo_empty;

    // dv_q resets high so a data_valid already asserted at reset release is not a frame start.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dv_q      <= 1'b1;
            phase     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            dv_q   <= bus.data_valid;
            push_q <= 1'b0;

            // Clear first so an error raised in the same cycle overrides it.
            if (clr_err) begin
                frame_err <= 1'b0;
                overflow  <= 1'b0;
            end

            if (push_q) begin
                if (push_ok) begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.data_valid && !dv_q) begin
                        phase   <= PH_W'(1);
                        bit_idx <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!bus.data_valid && !last_sample) begin
                        frame_err <= 1'b1;
                        shreg     <= '0;
                        state     <= S_IDLE;
                    end else begin
                        phase <= (phase == PH_W'(BIT_CYCLES - 1)) ? '0 : phase + PH_W'(1);
                        if (sample) begin
                            shreg   <= {shreg[DATA_W-2:0], bus.s_data};
                            bit_idx <= bit_idx + BI_W'(1);
                        end
                        if (last_sample) begin
                            bit_idx <= '0;
                            push_q  <= 1'b1;
                            state   <= S_WAIT_LOW;
                        end
                    end
                end
                S_WAIT_LOW: begin
                    if (!bus.data_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // shreg holds the finished word until the next frame's first sample, long after the push.
    sync_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_50M),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (shreg),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_s2p_rx.sv
// Scoreboard bench for s2p_rx: frames are driven bit-serially and expected words queued.
// The word counter is narrowed to 4 bits so its wrap is reached in a few frames.
module tb_s2p_rx;

    import s2p_rx_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int BC     = BIT_CYCLES;
    localparam int FULL_LEN = WORD_W * BC;

    logic             clk_50M = 1'b0;
    logic             rst;
    logic             clr_err;
    logic             frame_err;
    logic             overflow;
    logic [CNT_W-1:0] word_cnt;

    s2p_rx_if #(.WIDTH(WORD_W)) bus ();

    s2p_rx #(
        .BITS_ADC   (BITS_ADC),
        .BIT_CYCLES (BC),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .bus       (bus),
        .clr_err   (clr_err),
        .frame_err (frame_err),
        .overflow  (overflow),
        .word_cnt  (word_cnt)
    );

    always #10 clk_50M = ~clk_50M;

    int               checks = 0;
    int               errors = 0;
    logic [WORD_W-1:0] exp_q[$];
    int               exp_cnt;
    logic             exp_ferr;
    logic             exp_ovf;
    logic             empty_at_150;
    logic             empty_at_151;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cnt  = 0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic applyReset();
        rst            = 1'b1;
        clr_err        = 1'b0;
        bus.data_valid = 1'b0;
        bus.s_data     = 1'b0;
        bus.rd_en      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_empty"}, 32'(bus.empty), 32'(exp_q.size() == 0));
        checkOutput({tag, "_full"}, 32'(bus.full), 32'(exp_q.size() == DEPTH));
        checkOutput({tag, "_cnt"}, 32'(word_cnt), 32'(exp_cnt % (1 << CNT_W)));
        checkOutput({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        if (exp_q.size() != 0) begin
            checkOutput({tag, "_head"}, 32'(bus.rd_data), 32'(exp_q[0]));
        end
    endtask

    task automatic popWord(input string tag);
        checkOutput({tag, "_notempty"}, 32'(bus.empty), 32'd0);
        checkOutput(tag, 32'(bus.rd_data), 32'(exp_q[0]));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        void'(exp_q.pop_front());
    endtask

    // len edges of data_valid; a full frame is WORD_W*BC edges starting at the rising edge T0.
    task automatic applyStimulus(input logic [WORD_W-1:0] word, input int len,
                                 input bit pop_at_push, input bit rst_mid);
        for (int j = 0; j < len; j++) begin
            bus.data_valid = 1'b1;
            bus.s_data     = word[WORD_W-1-(j/BC)];
            if (pop_at_push && j == 151) begin
                bus.rd_en = 1'b1;
                checkOutput("pop_at_push_head", 32'(bus.rd_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            tick();
            bus.rd_en = 1'b0;
            if (j == 150) empty_at_150 = bus.empty;
            if (j == 151) empty_at_151 = bus.empty;
        end
        if (rst_mid) begin
            rst = 1'b1;
            tick();
            tick();
            bus.data_valid = 1'b0;
            rst = 1'b0;
            tick();
            model_reset();
        end else begin
            bus.data_valid = 1'b0;
            tick();
            tick();
            if (len == FULL_LEN) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(word);
                    exp_cnt++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end else begin
                exp_ferr = 1'b1;
            end
        end
    endtask

    task automatic pulseClear();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    initial begin
        logic [WORD_W-1:0] w;

        // Reset values and a single frame with its push latency.
        applyReset();
        checkState("reset");
        checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);
        applyStimulus(13'h1A5C, FULL_LEN, 1'b0, 1'b0);
        checkOutput("lat_empty_t150", 32'(empty_at_150), 32'd1);
        checkOutput("lat_empty_t151", 32'(empty_at_151), 32'd0);
        checkState("single");
        popWord("single_pop");
        checkState("single_after_pop");

        // Short frame, recovery frame, then clearing the sticky flag.
        applyReset();
        applyStimulus(13'h1234, 5 * BC, 1'b0, 1'b0);
        checkState("short");
        applyStimulus(13'h0FFF, FULL_LEN, 1'b0, 1'b0);
        checkState("recover");
        popWord("recover_pop");
        pulseClear();
        checkState("clr_ferr");

        // Five frames with no reads: the fifth overflows.
        applyReset();
        for (int i = 1; i <= 5; i++) begin
            w = WORD_W'(i);
            applyStimulus(w, FULL_LEN, 1'b0, 1'b0);
            if (i == 4) checkState("fill4");
        end
        checkState("overflow");
        for (int i = 0; i < 4; i++) popWord("ovf_pop");
        checkState("ovf_drained");
        pulseClear();
        checkState("clr_ovf");

        // Pop on the very cycle the fifth word is pushed into a full FIFO.
        applyReset();
        for (int i = 1; i <= 5; i++) begin
            w = WORD_W'(i);
            applyStimulus(w, FULL_LEN, (i == 5), 1'b0);
        end
        checkState("pop_push");
        for (int i = 0; i < 4; i++) popWord("pop_push_pop");
        checkState("pop_push_drained");

        // Reset in the middle of a frame, then a clean frame.
        applyReset();
        applyStimulus(13'h1555, 80, 1'b0, 1'b1);
        checkState("mid_reset");
        checkOutput("mid_reset_rd_data", 32'(bus.rd_data), 32'd0);
        applyStimulus(13'h0AAA, FULL_LEN, 1'b0, 1'b0);
        checkState("after_reset");
        popWord("after_reset_pop");

        // data_valid high across reset release must not start a frame.
        rst            = 1'b1;
        bus.data_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 200; i++) begin
            bus.s_data = i[2];
            tick();
        end
        checkState("dv_high_at_reset");
        bus.data_valid = 1'b0;
        tick();

        // Enough frames to wrap the narrowed word counter.
        for (int i = 0; i < 20; i++) begin
            w = WORD_W'($urandom_range(0, (1 << WORD_W) - 1));
            applyStimulus(w, FULL_LEN, 1'b0, 1'b0);
            popWord("wrap_pop");
        end
        checkState("wrap");
        checkOutput("wrap_cnt_value", 32'(word_cnt), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
